// File: rtl/rot_mask_right.sv
// rot_mask_right: two-stage valid/ready pipe doing per-word rotate-right (ROTR),
// logical shift-right (ROTM) and arithmetic shift-right (ROTMA) on a 128-bit quadword.
module rot_mask_right (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:1]   op,
    input  logic [0:6]   rt_in,
    input  logic [0:127] ra,
    input  logic [0:127] rb,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:6]   rt_out,
    output logic [0:127] result
);
    localparam logic [1:0] OP_ROTR  = 2'b00;
    localparam logic [1:0] OP_ROTM  = 2'b01;
    localparam logic [1:0] OP_ROTMA = 2'b10;

    logic            s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [1:0]      s1_op_q, s1_op_d;
    logic [6:0]      s1_rt_q, s1_rt_d, s2_rt_q, s2_rt_d;
    logic [0:127]    s1_ra_q, s1_ra_d, s2_res_q, s2_res_d, shifted;
    logic [3:0][5:0] s1_cnt_q, s1_cnt_d, cnt_dec;
    logic            s2_free, s1_adv, accept;
    logic            unused_rb;

    assign s2_free   = !s2_valid_q || out_ready;
    assign s1_adv    = s1_valid_q && s2_free;
    assign in_ready  = !s1_valid_q || s2_free;
    assign accept    = in_valid && in_ready && !flush;
    assign out_valid = s2_valid_q;
    assign rt_out    = s2_rt_q;
    assign result    = s2_res_q;
    assign unused_rb = ^rb;

    // Counts are decoded at issue so S1 only holds 6 bits per word; bit 5 means "shift out everything".
    for (genvar j = 0; j < 4; j++) begin : g_word
        logic [31:0] w;
        logic [5:0]  n;
        assign cnt_dec[j] = op == OP_ROTR ? {1'b0, rb[32*j+27 +: 5]} : 6'd0 - rb[32*j+26 +: 6];
        assign w = s1_ra_q[32*j +: 32];
        assign n = s1_cnt_q[j];
        assign shifted[32*j +: 32] =
            s1_op_q == OP_ROTR  ? 32'({w, w} >> n[4:0]) :
            s1_op_q == OP_ROTM  ? (n[5] ? 32'd0 : w >> n[4:0]) :
            s1_op_q == OP_ROTMA ? (n[5] ? {32{w[31]}} : 32'($signed(w) >>> n[4:0])) :
            32'd0;
    end

    always_comb begin
        s1_valid_d = flush ? 1'b0 : accept ? 1'b1 : s1_adv ? 1'b0 : s1_valid_q;
        s1_op_d    = accept ? op : s1_op_q;
        s1_rt_d    = accept ? rt_in : s1_rt_q;
        s1_ra_d    = accept ? ra : s1_ra_q;
        s1_cnt_d   = accept ? cnt_dec : s1_cnt_q;
        s2_valid_d = flush ? 1'b0 : s1_adv ? 1'b1 : out_ready ? 1'b0 : s2_valid_q;
        s2_rt_d    = s1_adv ? s1_rt_q : s2_rt_q;
        s2_res_d   = s1_adv ? shifted : s2_res_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_rt_q    <= '0;
            s1_ra_q    <= '0;
            s1_cnt_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_rt_q    <= '0;
            s2_res_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_rt_q    <= s1_rt_d;
            s1_ra_q    <= s1_ra_d;
            s1_cnt_q   <= s1_cnt_d;
            s2_valid_q <= s2_valid_d;
            s2_rt_q    <= s2_rt_d;
            s2_res_q   <= s2_res_d;
        end
    end
endmodule

// File: tb/tb_rot_mask_right.sv
// tb_rot_mask_right: scoreboard bench for rot_mask_right with directed and random traffic.
module tb_rot_mask_right;
    logic         clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
    logic [0:1]   op = '0;
    logic [0:6]   rt_in = '0;
    logic [0:127] ra = '0, rb = '0;
    logic         in_ready, out_valid;
    logic [0:6]   rt_out;
    logic [0:127] result;

    rot_mask_right dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rt_in(rt_in), .ra(ra), .rb(rb), .out_valid(out_valid),
        .out_ready(out_ready), .rt_out(rt_out), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]   rt;
        logic [127:0] res;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, errors = 0, acc_cnt = 0;
    bit   done = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Reference: MSB-0 bit indexing straight from the rotate formula; shifts via wide sign/zero extension.
    function automatic logic [0:127] model(input logic [1:0] o, input logic [0:127] a, input logic [0:127] b);
        logic [0:127] r;
        r = '0;
        for (int j = 0; j < 4; j++) begin
            logic [0:31] t, w;
            logic [31:0] c;
            logic [95:0] s;
            int n;
            t = a[32*j +: 32];
            c = b[32*j +: 32];
            w = '0;
            if (o == 2'd0) begin
                n = int'(c % 32);
                for (int k = 0; k < 32; k++) w[k] = t[(k - n + 32) % 32];
            end else if (o != 2'd3) begin
                n = int'((32'd0 - c) % 64);
                s = {{64{o == 2'd2 && t[0]}}, t};
                s = s >> n;
                w = s[31:0];
            end
            r[32*j +: 32] = w;
        end
        return r;
    endfunction

    function automatic logic [0:127] rand_cnt();
        logic [0:127] b;
        for (int j = 0; j < 4; j++) begin
            int sel;
            sel = int'($urandom_range(0, 3));
            b[32*j +: 32] = sel == 0 ? $urandom() :
                            sel == 1 ? 32'($urandom_range(0, 40)) :
                            sel == 2 ? 32'd0 - 32'($urandom_range(0, 70)) :
                            ($urandom_range(0, 1) != 0 ? 32'hFFFFFFE0 : 32'h00000020);
        end
        return b;
    endfunction

    function automatic logic [0:127] rand_data();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic send(input logic [1:0] o, input logic [6:0] r, input logic [0:127] a, input logic [0:127] b);
        bit acc;
        acc = 0;
        @(negedge clk);
        op = o; rt_in = r; ra = a; rb = b; in_valid = 1;
        for (int k = 0; k < 200 && !acc; k++) begin
            if (k > 0) @(negedge clk);
            #1 acc = in_ready && !flush;
            @(posedge clk);
        end
        #1 in_valid = 0;
        if (acc) begin
            sb.push_back('{rt: r, res: model(o, a, b)});
            acc_cnt++;
        end else fail_now("send_accept");
    endtask

    task automatic wait_valid();
        bit seen;
        seen = 0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            #3 seen = out_valid;
        end
        if (!seen) fail_now("wait_valid");
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) fail_now("drain");
        repeat (2) @(negedge clk);
    endtask

    initial begin : monitor
        bit           held;
        logic [127:0] hres;
        logic [6:0]   hrt;
        exp_t         e;
        held = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) held = 0;
            else begin
                if (held && out_valid) begin
                    chk("hold_result", result, hres);
                    chk("hold_rt", rt_out, hrt);
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out: got rt %h result %h, expected nothing", rt_out, result);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_rt", rt_out, e.rt);
                        chk("sb_result", result, e.res);
                    end
                end
                held = out_valid && !out_ready;
                hres = result;
                hrt  = rt_out;
            end
        end
    end

    initial begin
        int           base;
        logic [127:0] snap;
        repeat (3) @(negedge clk);
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_result", result, 0);
        chk("rst_rt", rt_out, 0);
        @(negedge clk);
        rst_n = 1;
        out_ready = 1;

        send(2'd0, 7'h15, {32'h80000001, 96'h0123456789ABCDEF01234567}, {32'h00000021, 96'h3_00000007_FFFFFFFF});
        @(negedge clk); #3 chk("lat_edge_k", out_valid, 0);
        @(negedge clk); #3 chk("lat_edge_k1", out_valid, 1);
        chk("rotr_w0", result[0:31], 32'hC0000000);
        chk("rotr_rt", rt_out, 7'h15);

        send(2'd1, 7'h2A, {4{32'h80000001}}, {32'hFFFFFFFF, 32'h0, 32'hFFFFFFE0, 32'hFFFFFFF0});
        wait_valid();
        chk("rotm", result, {32'h40000000, 32'h80000001, 32'h00000000, 32'h00008000});

        send(2'd2, 7'h2B, {4{32'h80000000}}, {32'hFFFFFFFC, 32'hFFFFFFE0, 32'h0, 32'hFFFFFFFF});
        wait_valid();
        chk("rotma", result, {32'hF8000000, 32'hFFFFFFFF, 32'h80000000, 32'hC0000000});

        send(2'd2, 7'h2C, {32'h40000000, 96'h0}, {32'hFFFFFFE0, 96'h0});
        wait_valid();
        chk("rotma_pos32", result[0:31], 32'h0);

        send(2'd3, 7'h3C, rand_data(), rand_cnt());
        wait_valid();
        chk("reserved_zero", result, 0);
        chk("reserved_rt", rt_out, 7'h3C);
        drain();

        @(negedge clk);
        out_ready = 0;
        base = acc_cnt;
        fork
            for (int i = 0; i < 4; i++) send(2'($urandom_range(0, 2)), 7'(7'h40 + i), rand_data(), rand_cnt());
            begin
                repeat (4) @(negedge clk);
                #3;
                chk("bp_in_ready_low", in_ready, 0);
                chk("bp_accepts", acc_cnt - base, 2);
                chk("bp_out_valid", out_valid, 1);
                snap = result;
                repeat (3) @(negedge clk);
                #3 chk("bp_stable", result, snap);
                @(negedge clk);
                out_ready = 1;
                for (int i = 0; i < 4; i++) begin
                    #3 chk("bp_stream", out_valid, 1);
                    @(negedge clk);
                end
                #3 chk("bp_stream_end", out_valid, 0);
            end
        join
        chk("bp_all_out", sb.size(), 0);
        drain();

        out_ready = 0;
        send(2'd0, 7'h50, rand_data(), rand_cnt());
        send(2'd1, 7'h51, rand_data(), rand_cnt());
        @(negedge clk);
        flush = 1; in_valid = 1; op = 2'd0; rt_in = 7'h52; ra = rand_data(); rb = rand_cnt();
        @(posedge clk);
        #1 flush = 0;
        in_valid = 0;
        sb.delete();
        @(negedge clk); #3 chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        @(negedge clk); #3 chk("flush_no_accept", out_valid, 0);
        out_ready = 1;
        send(2'd0, 7'h33, rand_data(), rand_cnt());
        @(negedge clk); #3 chk("flush_lat_k", out_valid, 0);
        @(negedge clk); #3 chk("flush_lat_k1", out_valid, 1);
        chk("flush_new_rt", rt_out, 7'h33);
        drain();

        out_ready = 0;
        send(2'd0, 7'h7F, {4{32'hA5A5A5A5}}, rand_cnt());
        send(2'd0, 7'h7E, {4{32'h5A5A5A5A}}, rand_cnt());
        @(posedge clk);
        #2 chk("pre_reset_valid", out_valid, 1);
        rst_n = 0;
        #1;
        chk("areset_out_valid", out_valid, 0);
        chk("areset_result", result, 0);
        chk("areset_rt", rt_out, 0);
        chk("areset_in_ready", in_ready, 1);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1;
        out_ready = 1;
        send(2'd0, 7'h11, {32'h00000001, 96'h0}, {32'h00000001, 96'h0});
        wait_valid();
        chk("post_reset_rotr", result[0:31], 32'h80000000);
        chk("post_reset_rt", rt_out, 7'h11);
        drain();

        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    send(2'($urandom_range(0, 3)), 7'($urandom()), rand_data(), rand_cnt());
                end
                done = 1;
            end
            while (!done) begin
                @(negedge clk);
                out_ready = $urandom_range(0, 3) != 0;
            end
        join
        out_ready = 1;
        drain();
        chk("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rot_mask_right.md
# rot_mask_right

Pipelined word rotate-right / rotate-and-mask unit for the FX2 execution pipe. It is the right-going counterpart of the FX2 word rotate-left block: ROTR, ROTM (logical shift right) and ROTMA (arithmetic shift right) operate on four 32-bit words of a 128-bit quadword. It sits between issue and the result forwarding network. A two-stage valid/ready pipeline carries the target-register tag alongside the data.

## Interface
- Parameters: none. Operand width is fixed at 128 bits, in four 32-bit words. Tag width is fixed at 7 bits.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous pipeline kill
- in_valid  in  1  input operation valid
- in_ready  out  1  unit can accept an operation this cycle
- op  in  [0:1]  00 ROTR, 01 ROTM, 10 ROTMA, 11 reserved
- rt_in  in  [0:6]  destination register tag
- ra  in  [0:127]  data operand; bit 0 is the MSB, word j = bits 32j..32j+31
- rb  in  [0:127]  count operand, one count per word
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- rt_out  out  [0:6]  tag of the result
- result  out  [0:127]  rotated/shifted quadword

## Operation
- **Per-word count**, from rb word j as 32-bit value c:
  - ROTR: n = c & 0x1F. Rotate right by n.
  - ROTM: n = (0 - c) & 0x3F. Logical shift right by n. If n >= 32 the word is 0.
  - ROTMA: n = (0 - c) & 0x3F. Arithmetic shift right by n. If n >= 32 every bit equals bit 0 of the ra word.
  - Reserved op 11: result is all zeros, and the tag still propagates.
- ROTR semantics: result bit b = t[(b - n) mod 32], where t is the ra word.
- Words are independent. No cross-word carry.
- **Stage S1** (registered at accept): latches op, rt, ra, and the four 6-bit decoded counts. Negation and masking happen before this register.
- **Stage S2** (registered when S1 advances): latches the shifted quadword and the tag.
- Outputs are driven directly from the S2 registers. No combinational path from ra/rb to result.
- **Handshake**:
  - s2_free = !s2_valid | out_ready.
  - s1_adv = s1_valid & s2_free.
  - in_ready = !s1_valid | s2_free.
  - Accept when in_valid & in_ready.
- **Flush**: at the next edge s1_valid and s2_valid clear. in_valid during a flush cycle is ignored, and nothing is accepted. Flush overrides both accept and out_ready.
- **Reset** (async, rst_n low):
  - s1_valid = 0, s2_valid = 0.
  - out_valid = 0, in_ready = 1.
  - result = 0, rt_out = 0.
  - Data registers clear to 0.
- **Reset mid-operation**: all in-flight operations are lost, with no partial output. Release is synchronous to clk through the flop reset.

## Timing
- Latency: an operation accepted at edge k has out_valid = 1 after edge k+1 when out_ready was not blocking. That is 2 cycles from in_valid to result.
- Throughput: one operation per cycle while out_ready = 1.
- **Backpressure**:
  - out_valid = 1 with out_ready = 0 holds result and rt_out stable.
  - S1 holds if occupied.
  - in_ready drops only when both stages are full and out_ready = 0.
- **Simultaneous accept and drain**: when both stages are full and out_ready = 1, in_ready = 1. All three moves (accept into S1, S1 to S2, S2 out) happen on the same edge with no bubble.
- Empty pipe: in_ready = 1 regardless of out_ready.
- Outputs change only on clock edges or on async reset.

## Test plan
- **ROTR**: ra word0 = 0x80000001, rb word0 = 0x00000021 (masked to 1).
  - Expect word0 = 0xC0000000.
  - rt_out = rt_in, out_valid 2 cycles after accept.
- **ROTM**: ra words all 0x80000001, rb words = 0xFFFFFFFF, 0x00000000, 0xFFFFFFE0, 0xFFFFFFF0.
  - Expect 0x40000000, 0x80000001, 0x00000000, 0x00008000.
- **ROTMA**: ra words all 0x80000000, rb words = 0xFFFFFFFC, 0xFFFFFFE0, 0x00000000, 0xFFFFFFFF.
  - Expect 0xF8000000, 0xFFFFFFFF, 0x80000000, 0xC0000000.
  - Positive word 0x40000000 with rb = 0xFFFFFFE0 gives 0.
- **Backpressure**: issue 4 back-to-back operations with out_ready = 0 from cycle 1.
  - in_ready falls after 2 accepts.
  - result holds stable.
  - Raise out_ready: all 4 emerge in order, one per cycle, with no loss or duplication.
- **Flush**: 2 operations in flight plus in_valid high on the flush cycle.
  - Next cycle out_valid = 0 and nothing is accepted.
  - A new operation issued afterwards returns in 2 cycles with its own tag.
- **Async reset**: assert rst_n low mid-stream, between clock edges.
  - out_valid, result and rt_out go to 0 immediately, and in_ready = 1.
  - After release, ROTR 0x00000001 by 1 returns 0x80000000.
